// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Frame layout is 8N1: one start, eight data, one stop bit.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int UART_DATA_BITS  = 8;
   localparam int UART_FRAME_BITS = 10;
   localparam int CLK_DIV_115200  = 868;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 serializer: start pulse latches a byte, then shifts it out LSB first.
// txd and busy are registered from the next-state decode.
module uart_tx_serializer
   import uart_pkg::*;
#(
   parameter int CLK_DIV = CLK_DIV_115200
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] data,
   output logic       busy,
   output logic       txd
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
   localparam logic [2:0] BIT_LAST = 3'(UART_DATA_BITS - 1);

   tx_state_t         state_q, state_d;
   logic [DW-1:0]     div_q, div_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        sh_q, sh_d;
   logic              txd_d, busy_d;
   logic              tick;

   assign tick = (div_q == DIV_LAST);

   // Next state, baud counter, bit index and shift register
   always_comb begin
      state_d = state_q;
      div_d   = div_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               sh_d    = data;
               div_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (tick) begin
               div_d   = '0;
               bit_d   = '0;
               state_d = DATA;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         DATA: begin
            if (tick) begin
               div_d = '0;
               if (bit_q == BIT_LAST) begin
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         STOP: begin
            if (tick) begin
               div_d   = '0;
               state_d = IDLE;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Line level and busy decoded from the state being entered
   always_comb begin
      txd_d  = 1'b1;
      busy_d = (state_d != IDLE);
      unique case (1'b1)
         (state_d == START): txd_d = 1'b0;
         (state_d == DATA):  txd_d = sh_d[bit_d];
         default:            txd_d = 1'b1;
      endcase
   end

   // State and output registers; reset aborts any frame at once
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         div_q   <= '0;
         bit_q   <= '0;
         sh_q    <= '0;
         txd     <= 1'b1;
         busy    <= 1'b0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         txd     <= txd_d;
         busy    <= busy_d;
      end
   end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one 8N1 transmitter among N_REQ requesters.
// Accept is combinational in idle; grant starts after the last granted index.
module uart_tx_sched
   import uart_pkg::*;
#(
   parameter int N_REQ   = 4,
   parameter int CLK_DIV = CLK_DIV_115200
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*8-1:0]       req_data,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     tx_en,
   output logic                     txd,
   output logic                     busy,
   output logic [$clog2(N_REQ)-1:0] grant_id,
   output logic [7:0]               byte_cnt
);

   localparam int GW = $clog2(N_REQ);
   localparam logic [GW-1:0] PTR_RST = GW'(N_REQ - 1);

   logic [GW-1:0] last_ptr;
   logic [GW-1:0] gsel;
   logic          hit;
   logic          accept;
   logic [7:0]    gdata;
   int            idx;

   // Priority scan upward from last_ptr+1, wrapping modulo N_REQ
   always_comb begin
      hit  = 1'b0;
      gsel = '0;
      idx  = 0;
      for (int k = 1; k <= N_REQ; k++) begin
         idx = (int'(last_ptr) + k) % N_REQ;
         if (!hit && req_valid[idx]) begin
            hit  = 1'b1;
            gsel = GW'(idx);
         end
      end
   end

   assign accept    = tx_en & ~busy & hit;
   assign req_ready = accept ? (N_REQ'(1) << gsel) : '0;
   assign gdata     = req_data[int'(gsel)*UART_DATA_BITS +: UART_DATA_BITS];

   // Pointer, visible grant index and frame counter update on accept
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_ptr <= PTR_RST;
         grant_id <= '0;
         byte_cnt <= '0;
      end else if (accept) begin
         last_ptr <= gsel;
         grant_id <= gsel;
         byte_cnt <= byte_cnt + 8'd1;
      end
   end

   uart_tx_serializer #(
      .CLK_DIV (CLK_DIV)
   ) u_ser (
      .clk   (clk),
      .rst_n (rst_n),
      .start (accept),
      .data  (gdata),
      .busy  (busy),
      .txd   (txd)
   );

endmodule

// File: tb/tb_uart_tx_sched.sv
// Randomized bench for uart_tx_sched against a frame-timing reference model.
// Model tracks remaining frame time and derives each line bit arithmetically.
module tb_uart_tx_sched;

   localparam int N  = 4;
   localparam int CD = 4;
   localparam int FR = 10 * CD;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N*8-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           tx_en;
   logic           txd;
   logic           busy;
   logic [1:0]     grant_id;
   logic [7:0]     byte_cnt;

   always #5 clk = ~clk;

   uart_tx_sched #(
      .N_REQ   (N),
      .CLK_DIV (CD)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .tx_en     (tx_en),
      .txd       (txd),
      .busy      (busy),
      .grant_id  (grant_id),
      .byte_cnt  (byte_cnt)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // stimulus state
   logic [N-1:0] vld;
   logic [7:0]   dat [N];
   logic         en;
   int           mode;
   bit           churn;

   // reference model state
   int         m_last, m_gid, m_cnt, m_rem;
   logic [7:0] m_byte;
   int         cyc;
   int         grants[$];
   int         acc_cyc[$];
   int         busy_cyc;
   int         wraps;
   logic [7:0] prev_cnt;

   task automatic model_reset();
      m_last = N - 1;
      m_gid  = 0;
      m_cnt  = 0;
      m_rem  = 0;
      m_byte = 8'h00;
   endtask

   function automatic int scan(input logic [N-1:0] v, input int last);
      for (int k = 1; k <= N; k++) begin
         int i;
         i = (last + k) % N;
         if (v[i]) return i;
      end
      return -1;
   endfunction

   function automatic logic exp_txd();
      int pos;
      if (m_rem == 0) return 1'b1;
      pos = (FR - m_rem) / CD;
      if (pos == 0) return 1'b0;
      if (pos == 9) return 1'b1;
      return m_byte[pos-1];
   endfunction

   task automatic tick();
      int           g;
      logic         acc;
      logic [N-1:0] exp_rdy;
      @(negedge clk);
      if (churn) begin
         for (int i = 0; i < N; i++) begin
            if (!vld[i] && $urandom_range(0, 3) == 0) begin
               dat[i] = 8'($urandom);
               vld[i] = 1'b1;
            end else if (vld[i] && $urandom_range(0, 15) == 0) begin
               vld[i] = 1'b0;
            end
         end
         en = ($urandom_range(0, 19) != 0);
      end
      req_valid = vld;
      for (int i = 0; i < N; i++) req_data[i*8 +: 8] = dat[i];
      tx_en = en;
      #1;
      chk("txd", 32'(txd), 32'(exp_txd()));
      chk("busy", 32'(busy), 32'(m_rem > 0));
      chk("grant_id", 32'(grant_id), m_gid);
      chk("byte_cnt", 32'(byte_cnt), m_cnt);
      if (busy === 1'b1) busy_cyc++;
      if (prev_cnt == 8'hff && byte_cnt == 8'h00) wraps++;
      prev_cnt = byte_cnt;
      g   = scan(vld, m_last);
      acc = en && (m_rem == 0) && (g >= 0);
      exp_rdy = acc ? (N'(1) << g) : '0;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      cyc++;
      if (acc) begin
         m_last = g;
         m_gid  = g;
         m_cnt  = (m_cnt + 1) % 256;
         m_rem  = FR;
         m_byte = dat[g];
         grants.push_back(g);
         acc_cyc.push_back(cyc);
         case (mode)
            0: vld[g] = 1'b0;
            2: begin
               dat[g] = 8'($urandom);
               vld[g] = 1'($urandom);
            end
            default: ;
         endcase
      end else if (m_rem > 0) begin
         m_rem--;
      end
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic wait_grants(input int n, input int budget);
      int k;
      k = 0;
      while (grants.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("wait_grant", 32'(grants.size() >= n), 32'd1);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n     = 1'b0;
      vld       = '0;
      req_valid = '0;
      model_reset();
      #2;
      rst_n = 1'b1;
      grants.delete();
      acc_cyc.delete();
   endtask

   initial begin
      int base;
      rst_n     = 1'b0;
      vld       = '0;
      en        = 1'b0;
      mode      = 0;
      churn     = 1'b0;
      req_valid = '0;
      req_data  = '0;
      tx_en     = 1'b0;
      cyc       = 0;
      busy_cyc  = 0;
      wraps     = 0;
      prev_cnt  = 8'h00;
      for (int i = 0; i < N; i++) dat[i] = 8'h00;
      model_reset();
      repeat (3) @(negedge clk);
      #1;
      chk("rst_txd", 32'(txd), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_gid", 32'(grant_id), 32'd0);
      chk("rst_cnt", 32'(byte_cnt), 32'd0);
      rst_n = 1'b1;

      // single byte 0x55 from requester 0
      en     = 1'b1;
      dat[0] = 8'h55;
      vld    = 4'b0001;
      busy_cyc = 0;
      wait_grants(1, 20);
      ticks(50);
      chk("t1_grant", grants[0], 0);
      chk("t1_count", grants.size(), 1);
      chk("t1_busy_len", busy_cyc, FR);
      chk("t1_cnt", 32'(byte_cnt), 32'd1);

      // all four valid, persistent: 0,1,2,3,0 at 41-clock period
      do_reset();
      mode = 1;
      for (int i = 0; i < N; i++) dat[i] = 8'(8'hA0 + i);
      vld = 4'b1111;
      wait_grants(5, 5 * (FR + 1) + 20);
      for (int i = 0; i < 5 && i < grants.size(); i++)
         chk("t2_order", grants[i], i % N);
      for (int i = 1; i < 5 && i < acc_cyc.size(); i++)
         chk("t2_period", acc_cyc[i] - acc_cyc[i-1], FR + 1);
      ticks(FR + 2);

      // fairness with requesters 1 and 2
      do_reset();
      mode = 1;
      vld  = 4'b0110;
      wait_grants(3, 3 * (FR + 1) + 20);
      if (grants.size() >= 3) begin
         chk("t3_g0", grants[0], 1);
         chk("t3_g1", grants[1], 2);
         chk("t3_g2", grants[2], 1);
      end
      ticks(FR + 2);

      // tx_en drop mid-frame
      do_reset();
      mode = 1;
      vld  = 4'b1111;
      wait_grants(1, 20);
      ticks(10);
      en = 1'b0;
      ticks(3 * FR);
      chk("t4_hold", grants.size(), 1);
      en   = 1'b1;
      base = cyc;
      tick();
      chk("t4_regrant", grants.size(), 2);
      if (acc_cyc.size() >= 2) chk("t4_when", acc_cyc[1], base + 1);
      tick();

      // reset in the middle of data bit 3
      ticks(CD + 3 * CD);
      chk("t5_busy_pre", 32'(busy), 32'd1);
      @(negedge clk);
      rst_n     = 1'b0;
      vld       = '0;
      req_valid = '0;
      #1;
      chk("t5_txd", 32'(txd), 32'd1);
      chk("t5_busy", 32'(busy), 32'd0);
      chk("t5_cnt", 32'(byte_cnt), 32'd0);
      chk("t5_gid", 32'(grant_id), 32'd0);
      model_reset();
      #1;
      rst_n = 1'b1;
      grants.delete();
      acc_cyc.delete();
      vld = 4'b1111;
      wait_grants(1, 20);
      if (grants.size() >= 1) chk("t5_first", grants[0], 0);

      // randomized traffic across the byte_cnt wrap
      mode  = 2;
      churn = 1'b1;
      wait_grants(260, 260 * (FR + 1) * 3);
      chk("t6_wrap", 32'(wraps >= 1), 32'd1);
      churn = 1'b0;
      en    = 1'b1;
      vld   = '0;
      ticks(FR + 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
